// File: rtl/wb_pkg.sv
// Shared definitions for the writeback buffer: lane count, data width and queue entry type.
package wb_pkg;

   localparam int unsigned NLANES = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } wb_entry_t;

endpackage

// File: rtl/lane_compact.sv
// Packs the kept (valid, non-x0) lanes into slots 0..n_in-1, preserving lane order.
module lane_compact
   import wb_pkg::*;
#(
   parameter int unsigned WIDTH = 5
) (
   input  logic [NLANES-1:0]             i_valid,
   input  logic [NLANES-1:0][WIDTH-1:0]  i_waddr,
   input  logic [NLANES-1:0][DATA_W-1:0] i_wdata,
   output logic [NLANES-1:0][WIDTH-1:0]  o_waddr,
   output logic [NLANES-1:0][DATA_W-1:0] o_wdata,
   output logic [2:0]                    o_n_in
);

   logic [2:0] w_cnt;

   always_comb begin
      w_cnt   = '0;
      o_waddr = '0;
      o_wdata = '0;
      for (int k = 0; k < NLANES; k++) begin
         if (i_valid[k] && (i_waddr[k] != '0)) begin
            o_waddr[w_cnt[1:0]] = i_waddr[k];
            o_wdata[w_cnt[1:0]] = i_wdata[k];
            w_cnt               = w_cnt + 3'd1;
         end
      end
      o_n_in = w_cnt;
   end

endmodule

// File: rtl/wb_buffer.sv
// Writeback buffer: circular queue that absorbs up to 4 results per cycle and drains up to 4
// oldest entries per cycle into registered register-file write ports.
module wb_buffer
   import wb_pkg::*;
#(
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned DEPTH_LOG = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NLANES-1:0]    i_valid,
   input  logic [WIDTH-1:0]     i_waddr0,
   input  logic [WIDTH-1:0]     i_waddr1,
   input  logic [WIDTH-1:0]     i_waddr2,
   input  logic [WIDTH-1:0]     i_waddr3,
   input  logic [DATA_W-1:0]    i_wdata0,
   input  logic [DATA_W-1:0]    i_wdata1,
   input  logic [DATA_W-1:0]    i_wdata2,
   input  logic [DATA_W-1:0]    i_wdata3,
   output logic                 o_ready,
   input  logic                 i_hold,
   output logic                 o_we0,
   output logic                 o_we1,
   output logic                 o_we2,
   output logic                 o_we3,
   output logic [WIDTH-1:0]     o_waddr0,
   output logic [WIDTH-1:0]     o_waddr1,
   output logic [WIDTH-1:0]     o_waddr2,
   output logic [WIDTH-1:0]     o_waddr3,
   output logic [DATA_W-1:0]    o_wdata0,
   output logic [DATA_W-1:0]    o_wdata1,
   output logic [DATA_W-1:0]    o_wdata2,
   output logic [DATA_W-1:0]    o_wdata3,
   output logic [DEPTH_LOG:0]   o_count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG;
   localparam int unsigned CW    = DEPTH_LOG + 1;

   logic [WIDTH-1:0]              r_mem_addr [DEPTH];
   logic [DATA_W-1:0]             r_mem_data [DEPTH];
   logic [DEPTH_LOG-1:0]          r_head;
   logic [DEPTH_LOG-1:0]          r_tail;
   logic [CW-1:0]                 r_count;
   logic [NLANES-1:0]             r_we;
   logic [NLANES-1:0][WIDTH-1:0]  r_waddr;
   logic [NLANES-1:0][DATA_W-1:0] r_wdata;

   logic [NLANES-1:0][WIDTH-1:0]  w_in_addr;
   logic [NLANES-1:0][DATA_W-1:0] w_in_data;
   logic [NLANES-1:0][WIDTH-1:0]  w_cmp_addr;
   logic [NLANES-1:0][DATA_W-1:0] w_cmp_data;
   logic [2:0]                    w_n_kept;
   logic [2:0]                    w_n_in;
   logic [2:0]                    w_n_out;
   logic                          w_ready;

   assign w_in_addr = {i_waddr3, i_waddr2, i_waddr1, i_waddr0};
   assign w_in_data = {i_wdata3, i_wdata2, i_wdata1, i_wdata0};

   lane_compact #(
      .WIDTH (WIDTH)
   ) u_compact (
      .i_valid (i_valid),
      .i_waddr (w_in_addr),
      .i_wdata (w_in_data),
      .o_waddr (w_cmp_addr),
      .o_wdata (w_cmp_data),
      .o_n_in  (w_n_kept)
   );

   // Space for a whole group is checked against pre-edge count, so overflow cannot occur.
   assign w_ready = (r_count <= CW'(DEPTH - NLANES));
   assign w_n_in  = w_ready ? w_n_kept : 3'd0;
   assign w_n_out = i_hold ? 3'd0 :
                    (r_count >= CW'(NLANES)) ? 3'(NLANES) : r_count[2:0];

   // Storage is intentionally not reset; only pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int k = 0; k < NLANES; k++) begin
            if (3'(k) < w_n_in) begin
               r_mem_addr[r_tail + DEPTH_LOG'(k)] <= w_cmp_addr[k];
               r_mem_data[r_tail + DEPTH_LOG'(k)] <= w_cmp_data[k];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_we    <= '0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_head  <= r_head + DEPTH_LOG'(w_n_out);
         r_tail  <= r_tail + DEPTH_LOG'(w_n_in);
         r_count <= r_count + CW'(w_n_in) - CW'(w_n_out);
         for (int p = 0; p < NLANES; p++) begin
            if (3'(p) < w_n_out) begin
               r_we[p]    <= 1'b1;
               r_waddr[p] <= r_mem_addr[r_head + DEPTH_LOG'(p)];
               r_wdata[p] <= r_mem_data[r_head + DEPTH_LOG'(p)];
            end else begin
               r_we[p]    <= 1'b0;
            end
         end
      end
   end

   assign o_ready  = w_ready;
   assign o_count  = r_count;
   assign o_we0    = r_we[0];
   assign o_we1    = r_we[1];
   assign o_we2    = r_we[2];
   assign o_we3    = r_we[3];
   assign o_waddr0 = r_waddr[0];
   assign o_waddr1 = r_waddr[1];
   assign o_waddr2 = r_waddr[2];
   assign o_waddr3 = r_waddr[3];
   assign o_wdata0 = r_wdata[0];
   assign o_wdata1 = r_wdata[1];
   assign o_wdata2 = r_wdata[2];
   assign o_wdata3 = r_wdata[3];

endmodule
